// File: rtl/lsu_bus_master.sv
// Load/store unit bus master.
// Takes one memory access at a time from the MEM stage, checks size and
// alignment, drives a single-beat request on a simple valid/ready bus with
// byte enables and lane-replicated store data, waits (bounded) for load data,
// and returns a one-cycle response carrying the extended load data or an error.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // pipeline side
  input  logic        i_req_vld,
  input  logic        i_req_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_req_rdy,
  output logic        o_stall,
  output logic        o_rsp_vld,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  // bus side
  output logic        o_bus_vld,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_rdy,
  input  logic        i_bus_rvld,
  input  logic [31:0] i_bus_rdata
);

  // Last counter value before a load is declared lost.
  localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // captured request
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_ofs;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;

  // response payload, valid while in RESP
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  // load wait counter
  logic [5:0]  r_wait_cnt;
  logic        w_timeout;

  // request decode
  logic        w_bad_funct3;
  logic        w_misaligned;
  logic        w_illegal;
  logic [3:0]  w_be;
  logic [31:0] w_lane_wdata;

  // load extraction
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic [31:0] w_load_data;

  assign w_timeout = (r_wait_cnt == TIMEOUT_LAST);

  // Classify the incoming request: unknown size codes and misaligned
  // halfword/word accesses never reach the bus.
  always_comb begin
    if (i_req_we) begin
      w_bad_funct3 = (i_funct3 > 3'b010);
    end else begin
      w_bad_funct3 = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
    end
    w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    w_illegal    = w_bad_funct3 || w_misaligned;
  end

  // Byte enables follow access size, shifted to the addressed lane.
  always_comb begin
    case (i_funct3[1:0])
      2'b00:   w_be = 4'b0001 << i_addr[1:0];
      2'b01:   w_be = 4'b0011 << i_addr[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  // Store data is replicated so every enabled lane sees the right bytes
  // regardless of address offset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_wdata[8*gi +: 8] =
        (i_funct3[1:0] == 2'b00) ? i_wdata[7:0] :
        (i_funct3[1:0] == 2'b01) ? i_wdata[8*(gi % 2) +: 8] :
                                   i_wdata[8*gi +: 8];
    end
  endgenerate

  // Pick the addressed byte/halfword out of the returned word and extend it.
  always_comb begin
    w_rd_byte = i_bus_rdata[{r_ofs, 3'b000} +: 8];
    w_rd_half = r_ofs[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_rd_byte[7]}}, w_rd_byte};
      3'b100:  w_load_data = {24'h000000, w_rd_byte};
      3'b001:  w_load_data = {{16{w_rd_half[15]}}, w_rd_half};
      3'b101:  w_load_data = {16'h0000, w_rd_half};
      default: w_load_data = i_bus_rdata;
    endcase
  end

  // State register; reset abandons whatever access was in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode. Bus outputs are only driven in ADDR so the
  // bus sees zeros whenever no request is outstanding.
  always_comb begin
    w_next_state = r_state;
    o_req_rdy    = 1'b0;
    o_stall      = 1'b0;
    o_rsp_vld    = 1'b0;
    o_rsp_err    = 1'b0;
    o_rsp_rdata  = 32'h0000_0000;
    o_bus_vld    = 1'b0;
    o_bus_we     = 1'b0;
    o_bus_addr   = 32'h0000_0000;
    o_bus_wdata  = 32'h0000_0000;
    o_bus_be     = 4'b0000;
    case (r_state)
      S_IDLE: begin
        o_req_rdy = 1'b1;
        // held low during reset so the pipeline is not frozen by a stale request
        o_stall   = i_req_vld && i_rst_n;
        if (i_req_vld) begin
          w_next_state = w_illegal ? S_RESP : S_ADDR;
        end
      end
      S_ADDR: begin
        o_stall     = 1'b1;
        o_bus_vld   = 1'b1;
        o_bus_we    = r_we;
        o_bus_addr  = r_bus_addr;
        o_bus_wdata = r_bus_wdata;
        o_bus_be    = r_bus_be;
        if (i_bus_rdy) begin
          w_next_state = r_we ? S_RESP : S_DATA;
        end
      end
      S_DATA: begin
        o_stall = 1'b1;
        if (i_bus_rvld || w_timeout) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        o_rsp_vld    = 1'b1;
        o_rsp_err    = r_rsp_err;
        o_rsp_rdata  = r_rsp_rdata;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Capture the request fields and the bus-ready lane data on acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_ofs       <= 2'b00;
      r_bus_addr  <= 32'h0000_0000;
      r_bus_wdata <= 32'h0000_0000;
      r_bus_be    <= 4'b0000;
    end else if ((r_state == S_IDLE) && i_req_vld) begin
      r_we        <= i_req_we;
      r_funct3    <= i_funct3;
      r_ofs       <= i_addr[1:0];
      r_bus_addr  <= {i_addr[31:2], 2'b00};
      r_bus_wdata <= w_lane_wdata;
      r_bus_be    <= w_be;
    end
  end

  // Build the response payload on the way into RESP; stores and errors
  // return zero data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_vld) begin
            r_rsp_err   <= w_illegal;
            r_rsp_rdata <= 32'h0000_0000;
          end
        end
        S_DATA: begin
          if (i_bus_rvld) begin
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load_data;
          end else if (w_timeout) begin
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'h0000_0000;
          end
        end
        default: begin
          r_rsp_err   <= r_rsp_err;
          r_rsp_rdata <= r_rsp_rdata;
        end
      endcase
    end
  end

  // Count cycles spent waiting for load data; zero on every entry to DATA.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 6'd0;
    end else if ((r_state == S_DATA) && (w_next_state == S_DATA)) begin
      r_wait_cnt <= r_wait_cnt + 6'd1;
    end else begin
      r_wait_cnt <= 6'd0;
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Testbench for lsu_bus_master: scenario tasks drive the pipeline and bus
// sides; expected responses are queued at issue and matched against the
// responses collected by a monitor.
module tb_lsu_bus_master;

  localparam int TO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_vld;
  logic        i_req_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_req_rdy;
  logic        o_stall;
  logic        o_rsp_vld;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_bus_vld;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_rdy;
  logic        i_bus_rvld;
  logic [31:0] i_bus_rdata;

  lsu_bus_master #(.TIMEOUT_CYC(TO)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_vld   (i_req_vld),
    .i_req_we    (i_req_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_req_rdy   (o_req_rdy),
    .o_stall     (o_stall),
    .o_rsp_vld   (o_rsp_vld),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_bus_vld   (o_bus_vld),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .o_bus_be    (o_bus_be),
    .i_bus_rdy   (i_bus_rdy),
    .i_bus_rvld  (i_bus_rvld),
    .i_bus_rdata (i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } act_t;

  exp_t exp_q[$];
  act_t act_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // collect every response pulse with the cycle it appeared in
  always @(negedge i_clk) begin
    if (o_rsp_vld) act_q.push_back(act_t'{rdata: o_rsp_rdata, err: o_rsp_err, cyc: cyc});
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    i_req_vld = 1'b1;
    i_req_we  = we;
    i_funct3  = f3;
    i_addr    = a;
    i_wdata   = wd;
  endtask

  task automatic wait_act(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      if (act_q.size() != 0) got = 1'b1;
      else tick();
    end
    if (act_q.size() != 0) got = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_req_vld = 1'b1; i_req_we = 1'b1; i_funct3 = 3'b010;
    i_addr = 32'h40; i_wdata = 32'h12345678;
    i_bus_rdy = 1'b1; i_bus_rvld = 1'b1; i_bus_rdata = 32'hFFFFFFFF;
    repeat (3) tick();
    n_checks++;
    if (o_req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_rdy: got %b want 1", o_req_rdy);
    end
    n_checks++;
    if ({o_stall, o_rsp_vld, o_rsp_err, o_bus_vld, o_bus_we} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {o_stall, o_rsp_vld, o_rsp_err, o_bus_vld, o_bus_we});
    end
    n_checks++;
    if ({o_rsp_rdata, o_bus_addr, o_bus_wdata, o_bus_be} !== 100'd0) begin
      n_fail++; $display("FAIL reset_data: rdata %h addr %h wdata %h be %b want all 0", o_rsp_rdata, o_bus_addr, o_bus_wdata, o_bus_be);
    end
    i_req_vld = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    n_checks++;
    if (o_req_rdy !== 1'b1 || act_q.size() != 0) begin
      n_fail++; $display("FAIL reset_release: req_rdy %b rsp_count %0d want 1/0", o_req_rdy, act_q.size());
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] bwd;
  } st_t;

  task automatic test_stores();
    st_t tbl[6];
    exp_t e; act_t a; bit got; int c0;
    tbl = '{
      '{3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5},
      '{3'b000, 32'h020, 32'h12345678, 4'b0001, 32'h78787878},
      '{3'b000, 32'h021, 32'h00000066, 4'b0010, 32'h66666666},
      '{3'b001, 32'h022, 32'hDEADBEEF, 4'b1100, 32'hBEEFBEEF},
      '{3'b001, 32'h020, 32'hDEADBEEF, 4'b0011, 32'hBEEFBEEF},
      '{3'b010, 32'h024, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D}
    };
    i_bus_rdy = 1'b1; i_bus_rvld = 1'b1; i_bus_rdata = 32'h5A5A5A5A;
    foreach (tbl[k]) begin
      c0 = cyc;
      issue(1'b1, tbl[k].f3, tbl[k].addr, tbl[k].wd);
      exp_q.push_back(exp_t'{rdata: 32'h0, err: 1'b0});
      tick();
      i_req_vld = 1'b0;
      n_checks++;
      if ({o_bus_vld, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata} !==
          {1'b1, 1'b1, tbl[k].addr & 32'hFFFFFFFC, tbl[k].be, tbl[k].bwd}) begin
        n_fail++;
        $display("FAIL store_bus[%0d]: vld %b we %b addr %h be %b wdata %h want 1 1 %h %b %h", k,
                 o_bus_vld, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
                 tbl[k].addr & 32'hFFFFFFFC, tbl[k].be, tbl[k].bwd);
      end
      wait_act(10, got);
      n_checks++;
      if (!got) begin
        n_fail++; $display("FAIL store_rsp_timeout[%0d]: got no response want one", k);
      end else begin
        e = exp_q.pop_front(); a = act_q.pop_front();
        if (a.rdata !== e.rdata || a.err !== e.err) begin
          n_fail++; $display("FAIL store_rsp[%0d]: rdata %h err %b want %h %b", k, a.rdata, a.err, e.rdata, e.err);
        end
        n_checks++;
        if (a.cyc - c0 + 1 != 3) begin
          n_fail++; $display("FAIL store_latency[%0d]: got %0d want 3", k, a.cyc - c0 + 1);
        end
      end
      tick();
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] res;
  } ld_t;

  task automatic test_loads();
    ld_t tbl[11];
    exp_t e; act_t a; bit got; int c0;
    tbl = '{
      '{3'b000, 32'h202, 32'h0080FF00, 32'hFFFFFF80},
      '{3'b100, 32'h202, 32'h0080FF00, 32'h00000080},
      '{3'b000, 32'h010, 32'h80FF7F01, 32'h00000001},
      '{3'b000, 32'h011, 32'h80FF7F01, 32'h0000007F},
      '{3'b000, 32'h013, 32'h80FF7F01, 32'hFFFFFF80},
      '{3'b100, 32'h012, 32'h80FF7F01, 32'h000000FF},
      '{3'b001, 32'h010, 32'h80FF7F01, 32'h00007F01},
      '{3'b001, 32'h012, 32'h80FF7F01, 32'hFFFF80FF},
      '{3'b101, 32'h012, 32'h80FF7F01, 32'h000080FF},
      '{3'b101, 32'h010, 32'h80FF8001, 32'h00008001},
      '{3'b010, 32'h014, 32'h80FF7F01, 32'h80FF7F01}
    };
    i_bus_rdy = 1'b1; i_bus_rvld = 1'b1;
    foreach (tbl[k]) begin
      i_bus_rdata = tbl[k].rd;
      c0 = cyc;
      issue(1'b0, tbl[k].f3, tbl[k].addr, 32'hFFFFFFFF);
      exp_q.push_back(exp_t'{rdata: tbl[k].res, err: 1'b0});
      tick();
      i_req_vld = 1'b0;
      n_checks++;
      if ({o_bus_vld, o_bus_we, o_bus_addr} !== {1'b1, 1'b0, tbl[k].addr & 32'hFFFFFFFC}) begin
        n_fail++; $display("FAIL load_bus[%0d]: vld %b we %b addr %h want 1 0 %h", k,
                           o_bus_vld, o_bus_we, o_bus_addr, tbl[k].addr & 32'hFFFFFFFC);
      end
      wait_act(10, got);
      n_checks++;
      if (!got) begin
        n_fail++; $display("FAIL load_rsp_timeout[%0d]: got no response want one", k);
      end else begin
        e = exp_q.pop_front(); a = act_q.pop_front();
        if (a.rdata !== e.rdata || a.err !== e.err) begin
          n_fail++; $display("FAIL load_rsp[%0d]: rdata %h err %b want %h %b", k, a.rdata, a.err, e.rdata, e.err);
        end
        n_checks++;
        if (a.cyc - c0 + 1 != 4) begin
          n_fail++; $display("FAIL load_latency[%0d]: got %0d want 4", k, a.cyc - c0 + 1);
        end
      end
      tick();
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
  } er_t;

  task automatic test_errors();
    er_t tbl[11];
    exp_t e; act_t a; bit got; int c0;
    tbl = '{
      '{1'b0, 3'b010, 32'h102},
      '{1'b0, 3'b001, 32'h101},
      '{1'b0, 3'b101, 32'h203},
      '{1'b1, 3'b010, 32'h101},
      '{1'b1, 3'b001, 32'h103},
      '{1'b0, 3'b011, 32'h000},
      '{1'b0, 3'b110, 32'h000},
      '{1'b0, 3'b111, 32'h004},
      '{1'b1, 3'b011, 32'h000},
      '{1'b1, 3'b100, 32'h008},
      '{1'b1, 3'b111, 32'h000}
    };
    i_bus_rdy = 1'b1; i_bus_rvld = 1'b1; i_bus_rdata = 32'hDEADBEEF;
    foreach (tbl[k]) begin
      c0 = cyc;
      issue(tbl[k].we, tbl[k].f3, tbl[k].addr, 32'h11111111);
      exp_q.push_back(exp_t'{rdata: 32'h0, err: 1'b1});
      tick();
      i_req_vld = 1'b0;
      n_checks++;
      if (o_bus_vld !== 1'b0 || o_rsp_vld !== 1'b1) begin
        n_fail++; $display("FAIL err_path[%0d]: bus_vld %b rsp_vld %b want 0 1", k, o_bus_vld, o_rsp_vld);
      end
      wait_act(10, got);
      n_checks++;
      if (!got) begin
        n_fail++; $display("FAIL err_rsp_timeout[%0d]: got no response want one", k);
      end else begin
        e = exp_q.pop_front(); a = act_q.pop_front();
        if (a.rdata !== e.rdata || a.err !== e.err) begin
          n_fail++; $display("FAIL err_rsp[%0d]: rdata %h err %b want %h %b", k, a.rdata, a.err, e.rdata, e.err);
        end
        n_checks++;
        if (a.cyc - c0 + 1 != 2) begin
          n_fail++; $display("FAIL err_latency[%0d]: got %0d want 2", k, a.cyc - c0 + 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    exp_t e; act_t a; bit got; int c0;
    i_bus_rdy = 1'b0; i_bus_rvld = 1'b1; i_bus_rdata = 32'h11223344;
    c0 = cyc;
    issue(1'b0, 3'b010, 32'h300, 32'h55AA55AA);
    exp_q.push_back(exp_t'{rdata: 32'h11223344, err: 1'b0});
    tick();
    i_req_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({o_bus_vld, o_bus_we, o_bus_addr, o_stall, o_rsp_vld} !== {1'b1, 1'b0, 32'h300, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: vld %b we %b addr %h stall %b rsp %b want 1 0 00000300 1 0", i,
                           o_bus_vld, o_bus_we, o_bus_addr, o_stall, o_rsp_vld);
      end
      if (i < 4) tick();
    end
    i_bus_rdy = 1'b1;
    tick();
    n_checks++;
    if (o_stall !== 1'b1 || o_bus_vld !== 1'b0) begin
      n_fail++; $display("FAIL stall_data: stall %b bus_vld %b want 1 0", o_stall, o_bus_vld);
    end
    wait_act(10, got);
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL stall_rsp_timeout: got no response want one");
    end else begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      if (a.rdata !== e.rdata || a.err !== e.err) begin
        n_fail++; $display("FAIL stall_rsp: rdata %h err %b want %h %b", a.rdata, a.err, e.rdata, e.err);
      end
      n_checks++;
      if (a.cyc - c0 + 1 != 8) begin
        n_fail++; $display("FAIL stall_latency: got %0d want 8", a.cyc - c0 + 1);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    exp_t e; act_t a; bit got; int c0;
    i_bus_rdy = 1'b1; i_bus_rvld = 1'b0; i_bus_rdata = 32'hDEADBEEF;
    c0 = cyc;
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    exp_q.push_back(exp_t'{rdata: 32'h0, err: 1'b1});
    tick();
    i_req_vld = 1'b0;
    wait_act(TO + 10, got);
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL timeout_rsp_missing: got no response want one");
    end else begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      if (a.rdata !== e.rdata || a.err !== e.err) begin
        n_fail++; $display("FAIL timeout_rsp: rdata %h err %b want %h %b", a.rdata, a.err, e.rdata, e.err);
      end
      n_checks++;
      if (a.cyc - (c0 + 2) != TO) begin
        n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", a.cyc - (c0 + 2), TO);
      end
    end
    tick();
    i_bus_rvld = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e; act_t a; bit got; int c0; int r;
    i_bus_rdy = 1'b1; i_bus_rvld = 1'b1; i_bus_rdata = 32'hA1B2C3D4;
    c0 = cyc;
    r = 0;
    issue(1'b1, 3'b010, 32'h500, 32'h01020304);
    exp_q.push_back(exp_t'{rdata: 32'h0, err: 1'b0});
    tick();
    n_checks++;
    if (o_req_rdy !== 1'b0 || o_stall !== 1'b1) begin
      n_fail++; $display("FAIL b2b_addr: req_rdy %b stall %b want 0 1", o_req_rdy, o_stall);
    end
    wait_act(10, got);
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL b2b_first_missing: got no response want one");
    end else begin
      n_checks++;
      if (o_req_rdy !== 1'b0 || o_stall !== 1'b0) begin
        n_fail++; $display("FAIL b2b_resp_cycle: req_rdy %b stall %b want 0 0", o_req_rdy, o_stall);
      end
      e = exp_q.pop_front(); a = act_q.pop_front();
      r = a.cyc;
      if (a.rdata !== e.rdata || a.err !== e.err || a.cyc - c0 + 1 != 3) begin
        n_fail++; $display("FAIL b2b_first: rdata %h err %b lat %0d want %h %b 3", a.rdata, a.err, a.cyc - c0 + 1, e.rdata, e.err);
      end
    end
    issue(1'b0, 3'b101, 32'h502, 32'h0);
    exp_q.push_back(exp_t'{rdata: 32'h0000A1B2, err: 1'b0});
    tick();
    n_checks++;
    if (o_req_rdy !== 1'b1 || o_stall !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: req_rdy %b stall %b want 1 1", o_req_rdy, o_stall);
    end
    tick();
    i_req_vld = 1'b0;
    wait_act(10, got);
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL b2b_second_missing: got no response want one");
    end else begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      if (a.rdata !== e.rdata || a.err !== e.err || a.cyc - r != 4) begin
        n_fail++; $display("FAIL b2b_second: rdata %h err %b gap %0d want %h %b 4", a.rdata, a.err, a.cyc - r, e.rdata, e.err);
      end
    end
    tick();
  endtask

  task automatic test_reset_in_data();
    exp_t e; act_t a; bit got; int c0;
    i_bus_rdy = 1'b1; i_bus_rvld = 1'b0; i_bus_rdata = 32'h12345678;
    issue(1'b0, 3'b010, 32'h600, 32'h0);
    tick();
    i_req_vld = 1'b0;
    tick();
    tick();
    n_checks++;
    if (o_stall !== 1'b1 || o_bus_vld !== 1'b0 || o_rsp_vld !== 1'b0) begin
      n_fail++; $display("FAIL rstdata_in_data: stall %b bus_vld %b rsp_vld %b want 1 0 0", o_stall, o_bus_vld, o_rsp_vld);
    end
    i_rst_n = 1'b0;
    i_bus_rvld = 1'b1;
    #1;
    n_checks++;
    if ({o_req_rdy, o_stall, o_rsp_vld, o_bus_vld, o_rsp_err} !== 5'b10000) begin
      n_fail++; $display("FAIL rstdata_async: got %b want 10000", {o_req_rdy, o_stall, o_rsp_vld, o_bus_vld, o_rsp_err});
    end
    tick();
    tick();
    n_checks++;
    if ({o_req_rdy, o_stall, o_rsp_vld, o_bus_vld} !== 4'b1000 || o_rsp_rdata !== 32'h0 || act_q.size() != 0) begin
      n_fail++; $display("FAIL rstdata_held: ctrl %b rdata %h rsp_count %0d want 1000 0 0",
                         {o_req_rdy, o_stall, o_rsp_vld, o_bus_vld}, o_rsp_rdata, act_q.size());
    end
    i_rst_n = 1'b1;
    c0 = cyc;
    issue(1'b1, 3'b010, 32'h604, 32'h0BADF00D);
    exp_q.push_back(exp_t'{rdata: 32'h0, err: 1'b0});
    tick();
    i_req_vld = 1'b0;
    n_checks++;
    if (o_bus_vld !== 1'b1 || o_bus_addr !== 32'h604 || o_bus_wdata !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL rstdata_first_req: vld %b addr %h wdata %h want 1 00000604 0badf00d", o_bus_vld, o_bus_addr, o_bus_wdata);
    end
    wait_act(10, got);
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL rstdata_rsp_missing: got no response want one");
    end else begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      if (a.rdata !== e.rdata || a.err !== e.err || a.cyc - c0 + 1 != 3) begin
        n_fail++; $display("FAIL rstdata_rsp: rdata %h err %b lat %0d want %h %b 3", a.rdata, a.err, a.cyc - c0 + 1, e.rdata, e.err);
      end
    end
    tick();
  endtask

  task automatic test_drain();
    repeat (5) tick();
    n_checks++;
    if (exp_q.size() != 0 || act_q.size() != 0) begin
      n_fail++; $display("FAIL drain: pending expected %0d unmatched responses %0d want 0 0", exp_q.size(), act_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_errors();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_reset_in_data();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, meaning max cycles waiting for load data before an error response.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_req_vld  input  1  pipeline presents a memory access (decoded mem_rden or mem_wren).
REQ-005 i_req_we  input  1  1 = store, 0 = load.
REQ-006 i_funct3  input  3  access size/sign: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
REQ-007 i_addr  input  32  byte address (ALU result).
REQ-008 i_wdata  input  32  store data (rs2), right-aligned.
REQ-009 o_req_rdy  output  1  request accepted this cycle.
REQ-010 o_stall  output  1  pipeline must hold the MEM stage.
REQ-011 o_rsp_vld  output  1  one-cycle completion pulse.
REQ-012 o_rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 o_rsp_err  output  1  misaligned, illegal funct3 or timeout; qualified by o_rsp_vld.
REQ-014 o_bus_vld / o_bus_we  output  1 each  bus request strobe and direction.
REQ-015 o_bus_addr  output  32  word address, bits [1:0] forced 00.
REQ-016 o_bus_wdata  output  32  lane-shifted store data.
REQ-017 o_bus_be  output  4  byte enables.
REQ-018 i_bus_rdy  input  1  bus accepts request while o_bus_vld high.
REQ-019 i_bus_rvld / i_bus_rdata  input  1 / 32  load data return.

Function
REQ-020 FSM states IDLE, ADDR, DATA, RESP; encoding free.
REQ-021 o_req_rdy = 1 only in IDLE; request captured when i_req_vld & o_req_rdy; address, funct3, we, wdata registered.
REQ-022 o_stall = i_req_vld in IDLE, 1 in ADDR and DATA, 0 in RESP.
REQ-023 Legal check at capture: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=00; store funct3 > 010 or load funct3 in {011,110,111} illegal.
REQ-024 Illegal/misaligned: IDLE -> RESP directly, no bus strobe, o_rsp_err=1.
REQ-025 Legal: IDLE -> ADDR; o_bus_vld held 1 with stable addr/we/wdata/be until i_bus_rdy.
REQ-026 ADDR with i_bus_rdy: store -> RESP; load -> DATA.
REQ-027 i_bus_rvld sampled only in DATA; any i_bus_rvld outside DATA is ignored.
REQ-028 DATA: i_bus_rvld -> RESP with extracted data; 6-bit wait counter cleared on entry; counter == TIMEOUT_CYC-1 without rvld -> RESP with o_rsp_err=1.
REQ-029 RESP lasts exactly one cycle, o_rsp_vld=1, then IDLE; no new request accepted in RESP.
REQ-030 Byte enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
REQ-031 Store lanes: SB byte replicated to all 4 lanes; SH halfword replicated to both halves; SW unchanged.
REQ-032 Load extraction: byte/halfword selected by addr[1:0], LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-033 Minimum latency: store 3 cycles capture-to-rsp with i_bus_rdy=1; load 4 cycles with rdy and rvld on first opportunity.

Reset
REQ-034 While i_rst_n=0: state IDLE, counter 0, all outputs 0 except o_req_rdy=1.
REQ-035 Reset asserted in any state aborts the transaction immediately; no o_rsp_vld for it after release.
REQ-036 First request accepted on first rising edge after i_rst_n deasserts.

Verification
REQ-037 SB addr 0x103, wdata 0x000000A5, rdy=1 -> o_bus_be=1000, o_bus_addr=0x100, o_bus_wdata=0xA5A5A5A5, rsp_vld cycle 3, err=0.
REQ-038 LB addr 0x202, rdata 0x0080FF00 -> o_rsp_rdata=0xFFFFFF80; same with LBU -> 0x00000080.
REQ-039 LW addr 0x102 -> no o_bus_vld, rsp_vld next cycle, err=1, rdata=0.
REQ-040 LW with i_bus_rdy low 5 cycles -> o_bus_vld and bus outputs stable all 5 cycles, stall=1 throughout.
REQ-041 LW, rvld never asserted -> err=1 exactly TIMEOUT_CYC cycles after entering DATA.
REQ-042 i_rst_n pulsed low in DATA -> outputs reset values, subsequent rvld ignored, no rsp_vld.
